// File: rtl/abc_frame_deser.sv
// Serial-to-frame deserializer: groups every three accepted bits into an {A,B,C}
// operand frame behind a valid/ready output register with a one-frame reserve.
module abc_frame_deser #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state_reg;
  logic [1:0]       idx_reg;
  logic [1:0]       slot_reg;
  logic [2:0]       hold_reg;
  logic             a_reg;
  logic             b_reg;
  logic             c_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic accept;
  logic handshake;
  logic slot_free;

  assign din_ready = (state_reg == COLLECT);
  // A bit arriving together with sync_clr is discarded along with the partial frame.
  assign accept    = din_valid && din_ready && !sync_clr;
  assign handshake = out_valid_reg && out_ready;
  assign slot_free = !out_valid_reg || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg[gi] <= 1'b0;
        end else if (accept && idx_reg == 2'(gi)) begin
          slot_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= COLLECT;
      idx_reg       <= 2'd0;
      hold_reg      <= 3'b000;
      a_reg         <= 1'b0;
      b_reg         <= 1'b0;
      c_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (handshake) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      case (state_reg)
        COLLECT: begin
          // A completing frame below overrides this drop, so back-to-back frames have no bubble.
          if (handshake) begin
            out_valid_reg <= 1'b0;
          end
          if (sync_clr) begin
            idx_reg <= 2'd0;
          end else if (accept) begin
            if (idx_reg == 2'd2) begin
              idx_reg <= 2'd0;
              if (slot_free) begin
                a_reg         <= slot_reg[0];
                b_reg         <= slot_reg[1];
                c_reg         <= din;
                out_valid_reg <= 1'b1;
              end else begin
                hold_reg  <= {slot_reg[0], slot_reg[1], din};
                state_reg <= HOLD;
              end
            end else begin
              idx_reg <= idx_reg + 2'd1;
            end
          end
        end
        default: begin
          if (handshake) begin
            a_reg     <= hold_reg[2];
            b_reg     <= hold_reg[1];
            c_reg     <= hold_reg[0];
            state_reg <= COLLECT;
          end
        end
      endcase
    end
  end

  assign A         = a_reg;
  assign B         = b_reg;
  assign C         = c_reg;
  assign out_valid = out_valid_reg;
  assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_abc_frame_deser.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops them on
// every output handshake; a second instance with a 2-bit counter checks wrap-around.
module tb_abc_frame_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_clr = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       din_ready, A, B, C, out_valid;
  logic [7:0] frame_cnt;
  logic       din_ready2, A2, B2, C2, out_valid2;
  logic [1:0] frame_cnt2;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  typedef struct {
    logic a;
    logic b;
    logic c;
    int   cnt_before;
  } frame_t;
  frame_t q[$];

  always #5 clk = ~clk;

  abc_frame_deser #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .A(A), .B(B), .C(C), .out_valid(out_valid),
    .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  abc_frame_deser #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready2), .A(A2), .B(B2), .C(C2), .out_valid(out_valid2),
    .out_ready(out_ready), .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    sync_clr = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    exp_frames = 0;
  endtask

  task automatic expect_frame(input logic a, input logic b, input logic c);
    frame_t f;
    f.a = a;
    f.b = b;
    f.c = c;
    f.cnt_before = exp_frames;
    q.push_back(f);
    exp_frames++;
  endtask

  task automatic send_bits(input logic [2:0] bits, input int n, input logic check_ready);
    for (int i = n - 1; i >= 0; i--) begin
      if (check_ready) chk("din_ready_stream", int'(din_ready), 1);
      din = bits[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got ABC=%b%b%b expected no frame", A, B, C);
      end else begin
        frame_t f;
        f = q.pop_front();
        if ({A, B, C} !== {f.a, f.b, f.c} || frame_cnt !== 8'(f.cnt_before)
            || frame_cnt2 !== 2'(f.cnt_before) || {A2, B2, C2} !== {f.a, f.b, f.c}) begin
          errors++;
          $display("FAIL frame: got ABC=%b%b%b cnt=%0d cnt2=%0d expected ABC=%b%b%b cnt=%0d",
                   A, B, C, frame_cnt, frame_cnt2, f.a, f.b, f.c, f.cnt_before);
        end else begin
          $display("ok   frame: ABC=%b%b%b cnt=%0d", A, B, C, frame_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_seq[5] = '{1, 2, 3, 0, 1};

    // Basic frame and reset state
    tick();
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_abc", int'({A, B, C}), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_din_ready", int'(din_ready), 1);
    out_ready = 1'b1;
    expect_frame(1, 0, 1);
    send_bits(3'b101, 3, 1'b0);
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_abc", int'({A, B, C}), 5);
    tick();
    chk("t1_frame_cnt", int'(frame_cnt), 1);
    chk("t1_out_valid_drop", int'(out_valid), 0);

    // Continuous stream at full throughput
    do_reset();
    expect_frame(1, 1, 0);
    expect_frame(0, 1, 1);
    send_bits(3'b110, 3, 1'b1);
    send_bits(3'b011, 3, 1'b1);
    tick();
    chk("t2_frame_cnt", int'(frame_cnt), 2);

    // Backpressure fills the reserve
    do_reset();
    out_ready = 1'b0;
    expect_frame(1, 0, 1);
    expect_frame(0, 1, 1);
    send_bits(3'b101, 3, 1'b0);
    send_bits(3'b011, 3, 1'b0);
    chk("t3_abc_stalled", int'({A, B, C}), 5);
    chk("t3_din_ready_hold", int'(din_ready), 0);
    out_ready = 1'b1;
    tick();
    chk("t3_abc_from_hold", int'({A, B, C}), 3);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_din_ready", int'(din_ready), 1);
    chk("t3_frame_cnt", int'(frame_cnt), 1);
    tick();
    chk("t3_drained", int'(out_valid), 0);
    chk("t3_frame_cnt2", int'(frame_cnt), 2);

    // sync_clr aborts a partial frame, including a same-cycle bit
    do_reset();
    send_bits(3'b011, 2, 1'b0);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    expect_frame(0, 0, 1);
    send_bits(3'b001, 3, 1'b0);
    tick();
    send_bits(3'b001, 1, 1'b0);
    sync_clr = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    tick();
    sync_clr = 1'b0;
    din_valid = 1'b0;
    expect_frame(1, 0, 0);
    send_bits(3'b100, 3, 1'b0);
    tick();
    tick();
    chk("t4_frame_cnt", int'(frame_cnt), 2);

    // Reset while in HOLD drops everything
    do_reset();
    out_ready = 1'b0;
    send_bits(3'b110, 3, 1'b0);
    send_bits(3'b010, 3, 1'b0);
    chk("t5_in_hold", int'(din_ready), 0);
    do_reset();
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_abc", int'({A, B, C}), 0);
    chk("t5_frame_cnt", int'(frame_cnt), 0);
    chk("t5_din_ready", int'(din_ready), 1);
    out_ready = 1'b1;
    expect_frame(1, 1, 1);
    send_bits(3'b111, 3, 1'b0);
    tick();
    chk("t5_frame_cnt_after", int'(frame_cnt), 1);

    // Counter wrap with a 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      expect_frame(k[0], 1'b1, k[1]);
      send_bits({k[0], 1'b1, k[1]}, 3, 1'b0);
      tick();
      chk("t6_cnt2_wrap", int'(frame_cnt2), cnt_seq[k]);
    end

    tick();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
